// File: rtl/sprite_anchor_issuer_pkg.sv
// Shared types and constants for the sprite anchor issuer: frame geometry,
// field widths, handshake FSM encoding and the buffered update payload.
package sprite_anchor_issuer_pkg;

  localparam int unsigned FRAME_W        = 640;
  localparam int unsigned FRAME_H        = 480;
  localparam int unsigned MAX_ANCORA_DEF = FRAME_W * FRAME_H - 1;

  localparam int unsigned SP_W    = 5;
  localparam int unsigned ANC_W   = 19;
  localparam int unsigned COUNT_W = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [SP_W-1:0]  sp_num;
    logic [ANC_W-1:0] ancora;
  } anchor_entry_t;

endpackage

// File: rtl/sprite_anchor_issuer_fifo.sv
// anchor_fifo: circular buffer of pending {sp_num, ancora} updates with
// registered occupancy and full flag; pushes while full are ignored.
module anchor_fifo
  import sprite_anchor_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  anchor_entry_t      din,
  output anchor_entry_t      dout,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  anchor_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count_d;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + COUNT_W'(1);
      2'b01:   count_d = count - COUNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == COUNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/sprite_anchor_issuer.sv
// Buffers processor anchor updates and issues them one at a time to the
// spriter through a change_rq / ready (busy-then-idle) handshake.
module sprite_anchor_issuer
  import sprite_anchor_issuer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned MAX_ANCORA  = MAX_ANCORA_DEF
) (
  input  logic               clk_75,
  input  logic               n_reset,
  input  logic               wr_en,
  input  logic [SP_W-1:0]    wr_sp_num,
  input  logic [ANC_W-1:0]   wr_ancora,
  output logic               wr_full,
  output logic [COUNT_W-1:0] fifo_count,
  output logic               change_rq,
  output logic [SP_W-1:0]    sp_num,
  output logic [ANC_W-1:0]   ancora_in,
  input  logic               ready,
  output logic               commit,
  output logic               err_range,
  output logic               err_timeout
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pop_c;
  logic             commit_d;
  logic             err_timeout_d;
  logic             timeout_c;
  logic             in_range_c;
  logic             fifo_empty;
  anchor_entry_t    head;
  anchor_entry_t    wr_entry;

  assign in_range_c = (32'(wr_ancora) <= MAX_ANCORA);
  assign wr_entry   = '{sp_num: wr_sp_num, ancora: wr_ancora};

  anchor_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_75),
    .rst_n (n_reset),
    .push  (wr_en && in_range_c),
    .pop   (pop_c),
    .din   (wr_entry),
    .dout  (head),
    .full  (wr_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state: the wait counter only runs while parked in a wait state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    pop_c         = 1'b0;
    commit_d      = 1'b0;
    err_timeout_d = 1'b0;
    timeout_c     = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    case (state_q)
      IDLE: begin
        if (!fifo_empty && ready) begin
          pop_c   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!ready) begin
          state_d = WAIT_DONE;
        end else if (timeout_c) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (ready) begin
          state_d  = IDLE;
          commit_d = 1'b1;
        end else if (timeout_c) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload is captured at pop and held until the next pop.
  always_ff @(posedge clk_75 or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      change_rq   <= 1'b0;
      commit      <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      sp_num      <= '0;
      ancora_in   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      change_rq   <= (state_d == ISSUE);
      commit      <= commit_d;
      err_range   <= wr_en && !in_range_c;
      err_timeout <= err_timeout_d;
      if (pop_c) begin
        sp_num    <= head.sp_num;
        ancora_in <= head.ancora;
      end
    end
  end

endmodule

// File: tb/tb_sprite_anchor_issuer.sv
// Directed plus randomized bench for sprite_anchor_issuer with a queue-based
// reference model of accepted updates and a scripted responder.
module tb_sprite_anchor_issuer;

  localparam int DEPTH = 8;
  localparam int TO    = 255;
  localparam int MAXA  = 307199;

  logic        clk_75 = 1'b0;
  logic        n_reset;
  logic        wr_en;
  logic [4:0]  wr_sp_num;
  logic [18:0] wr_ancora;
  logic        wr_full;
  logic [5:0]  fifo_count;
  logic        change_rq;
  logic [4:0]  sp_num;
  logic [18:0] ancora_in;
  logic        ready;
  logic        commit;
  logic        err_range;
  logic        err_timeout;

  sprite_anchor_issuer #(
    .FIFO_DEPTH (DEPTH),
    .ACK_TIMEOUT(TO),
    .MAX_ANCORA (MAXA)
  ) dut (
    .clk_75     (clk_75),
    .n_reset    (n_reset),
    .wr_en      (wr_en),
    .wr_sp_num  (wr_sp_num),
    .wr_ancora  (wr_ancora),
    .wr_full    (wr_full),
    .fifo_count (fifo_count),
    .change_rq  (change_rq),
    .sp_num     (sp_num),
    .ancora_in  (ancora_in),
    .ready      (ready),
    .commit     (commit),
    .err_range  (err_range),
    .err_timeout(err_timeout)
  );

  always #5 clk_75 = ~clk_75;

  int n_cmp = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];
  logic [23:0] cur = '0;
  int model_count = 0;
  int in_flight = 0;
  int acc_total = 0;
  int abandoned = 0;
  int n_commit = 0;
  int n_to = 0;
  int n_issue = 0;
  int cyc = 0;
  int last_issue_cyc = -100;
  int to_delay = 0;
  bit resp_mode = 1'b0;
  bit resp_rand = 1'b0;
  int resp_k = -1;
  int drop_k = 1;
  int raise_k = 3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: predict acceptance from the pre-edge inputs, then score the
  // post-edge outputs and advance the responder script.
  task automatic tick();
    logic acc, exp_er, rdy_before;
    logic [23:0] pushed;
    acc        = n_reset && wr_en && (model_count < DEPTH) && (32'(wr_ancora) <= MAXA);
    exp_er     = n_reset && wr_en && (32'(wr_ancora) > MAXA);
    pushed     = {wr_sp_num, wr_ancora};
    rdy_before = ready;
    @(posedge clk_75);
    #1;
    cyc++;
    check("commit_xor_timeout", 32'(commit & err_timeout), 0);
    if (commit || err_timeout) begin
      check("one_outstanding", in_flight, 1);
      in_flight = 0;
      resp_k = -1;
      if (commit) n_commit++;
      else begin
        n_to++;
        to_delay = cyc - last_issue_cyc;
      end
    end
    if (change_rq) begin
      check("issue_when_free", in_flight, 0);
      check("ready_at_issue", 32'(rdy_before), 1);
      check("issue_spacing", 32'((cyc - last_issue_cyc) >= 4), 1);
      check("issue_has_entry", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        model_count--;
      end
      check("issue_entry", {8'd0, sp_num, ancora_in}, {8'd0, cur});
      in_flight = 1;
      n_issue++;
      last_issue_cyc = cyc;
      if (resp_mode) begin
        resp_k = 0;
        if (resp_rand) begin
          drop_k  = $urandom_range(1, 3);
          raise_k = drop_k + $urandom_range(1, 3);
        end
      end
    end else begin
      if (in_flight != 0) check("hold_payload", {8'd0, sp_num, ancora_in}, {8'd0, cur});
      if (resp_k >= 0) resp_k++;
    end
    if (acc) begin
      exp_q.push_back(pushed);
      model_count++;
      acc_total++;
    end
    check("fifo_count", 32'(fifo_count), model_count);
    check("wr_full", 32'(wr_full), 32'(model_count == DEPTH));
    check("err_range", 32'(err_range), 32'(exp_er));
    if (resp_mode) ready = !(resp_k >= drop_k && resp_k < raise_k);
  endtask

  task automatic push(input logic [4:0] s, input logic [18:0] a);
    wr_en = 1'b1;
    wr_sp_num = s;
    wr_ancora = a;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset_async();
    n_reset = 1'b0;
    #1;
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_wr_full", 32'(wr_full), 0);
    check("rst_change_rq", 32'(change_rq), 0);
    check("rst_sp_num", 32'(sp_num), 0);
    check("rst_ancora_in", 32'(ancora_in), 0);
    check("rst_commit", 32'(commit), 0);
    check("rst_err_range", 32'(err_range), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    abandoned += model_count + in_flight;
    model_count = 0;
    in_flight = 0;
    exp_q.delete();
    resp_k = -1;
    last_issue_cyc = -100;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || in_flight != 0) && k < bound) begin
      tick();
      k++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && in_flight == 0), 1);
  endtask

  initial begin
    int c0, i0, t0, k;
    n_reset = 1'b1;
    wr_en = 1'b0;
    wr_sp_num = '0;
    wr_ancora = '0;
    ready = 1'b1;
    #2;
    do_reset_async();
    repeat (2) tick();
    n_reset = 1'b1;

    // Single update through a well-behaved responder.
    resp_mode = 1'b1; resp_rand = 1'b0; drop_k = 1; raise_k = 3;
    c0 = n_commit;
    push(5'd3, 19'd1000);
    check("first_push_count", 32'(fifo_count), 1);
    drain(30);
    check("single_commit", n_commit - c0, 1);
    check("single_sp_num", 32'(sp_num), 3);
    check("single_ancora", 32'(ancora_in), 1000);

    // Range boundary.
    push(5'd1, 19'd307200);
    check("range_pulse", 32'(err_range), 1);
    check("range_reject_count", 32'(fifo_count), 0);
    tick();
    push(5'd2, 19'd307199);
    check("range_max_accepted", 32'(fifo_count), 1);
    drain(30);
    check("range_max_issued", 32'(ancora_in), 307199);

    // Fill to full with the responder busy, then drain in order.
    resp_mode = 1'b0; ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(5'($urandom), 19'($urandom_range(0, MAXA)));
    check("full_flag", 32'(wr_full), 1);
    check("full_count", 32'(fifo_count), DEPTH);
    push(5'd31, 19'd77);
    check("drop_when_full", 32'(fifo_count), DEPTH);
    i0 = n_issue;
    resp_mode = 1'b1; ready = 1'b1;
    drain(100);
    check("drained_all", n_issue - i0, DEPTH);

    // Push and pop on the same edge.
    resp_mode = 1'b0; ready = 1'b0;
    for (int i = 0; i < 5; i++) push(5'(i + 10), 19'(i * 1111));
    check("five_queued", 32'(fifo_count), 5);
    resp_mode = 1'b1; ready = 1'b1;
    wr_en = 1'b1; wr_sp_num = 5'd20; wr_ancora = 19'd4242;
    tick();
    wr_en = 1'b0;
    check("push_pop_count", 32'(fifo_count), 5);
    check("push_pop_issue", 32'(change_rq), 1);
    drain(100);

    // Responder never goes busy: timeout.
    resp_mode = 1'b0; ready = 1'b1;
    t0 = n_to; c0 = n_commit;
    push(5'd9, 19'd5555);
    k = 0;
    while (n_to == t0 && k < 400) begin
      tick();
      k++;
    end
    check("timeout_seen", n_to - t0, 1);
    check("timeout_delay", to_delay, TO + 1);
    check("timeout_no_commit", n_commit - c0, 0);
    resp_mode = 1'b1;
    push(5'd10, 19'd6666);
    drain(30);
    check("after_timeout_commit", n_commit - c0, 1);

    // Reset in WAIT_DONE with three entries queued.
    resp_mode = 1'b0; ready = 1'b0;
    for (int i = 0; i < 4; i++) push(5'(i), 19'(i + 100));
    ready = 1'b1;
    tick();
    check("pre_reset_issue", 32'(change_rq), 1);
    ready = 1'b0;
    tick();
    tick();
    check("pre_reset_count", 32'(fifo_count), 3);
    #2;
    do_reset_async();
    repeat (2) tick();
    n_reset = 1'b1;
    ready = 1'b1;
    c0 = n_commit; i0 = n_issue;
    repeat (10) tick();
    check("no_commit_after_reset", n_commit - c0, 0);
    check("no_issue_after_reset", n_issue - i0, 0);

    // First edge after reset release accepts a push.
    #2;
    do_reset_async();
    tick();
    n_reset = 1'b1;
    push(5'd7, 19'd12345);
    check("push_first_edge", 32'(fifo_count), 1);
    resp_mode = 1'b1;
    drain(30);

    // Randomized traffic with a randomized responder.
    resp_mode = 1'b1; resp_rand = 1'b1; ready = 1'b1;
    repeat (400) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_sp_num = 5'($urandom);
      if ($urandom_range(0, 7) == 0) wr_ancora = 19'(MAXA + 1 + int'($urandom_range(0, 5000)));
      else wr_ancora = 19'($urandom_range(0, MAXA));
      tick();
    end
    wr_en = 1'b0;
    drain(400);
    check("accounting", n_commit + n_to + abandoned, acc_total);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_anchor_issuer.md
SPRITE_ANCHOR_ISSUER -- requirements
Module: sprite_anchor_issuer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the number of pending anchor updates buffered (power of two, 2..32).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum number of cycles spent waiting for the responder's ready transitions.
REQ-003 The block SHALL have parameter MAX_ANCORA, default 307199, meaning the largest legal anchor address (640x480 frame, row*640+column).
REQ-004 Port clk_75  input  1  sole clock; all logic on its rising edge.
REQ-005 Port n_reset  input  1  asynchronous, active-low reset.
REQ-006 Port wr_en  input  1  processor-side push of one update.
REQ-007 Port wr_sp_num  input  5  sprite index for the push.
REQ-008 Port wr_ancora  input  19  anchor address for the push.
REQ-009 Port wr_full  output  1  FIFO full; pushes are ignored while high.
REQ-010 Port fifo_count  output  6  number of buffered updates.
REQ-011 Port change_rq  output  1  request strobe to the spriter processor interface.
REQ-012 Port sp_num  output  5  sprite index presented with change_rq.
REQ-013 Port ancora_in  output  19  anchor address presented with change_rq.
REQ-014 Port ready  input  1  responder idle/accepting (high) or busy (low).
REQ-015 Port commit  output  1  one-cycle pulse when an update completes its handshake.
REQ-016 Port err_range  output  1  one-cycle pulse when a push is rejected for anchor > MAX_ANCORA.
REQ-017 Port err_timeout  output  1  one-cycle pulse when a handshake aborts on timeout.

Function
REQ-018 A push with wr_en=1, wr_full=0 and wr_ancora<=MAX_ANCORA SHALL be written to the FIFO, and fifo_count SHALL increment on the next edge.
REQ-019 A push with wr_ancora>MAX_ANCORA SHALL NOT be written, and err_range SHALL pulse on the next cycle; a push with wr_full=1 SHALL be dropped silently.
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-022 In IDLE, if the FIFO is non-empty and ready=1, the FSM SHALL pop the head, register it onto sp_num/ancora_in, and go to ISSUE.
REQ-023 In ISSUE, change_rq SHALL be 1 for exactly one cycle, after which the FSM SHALL go to WAIT_BUSY.
REQ-024 sp_num and ancora_in SHALL remain stable from ISSUE until the FSM returns to IDLE.
REQ-025 In WAIT_BUSY, ready=0 SHALL move the FSM to WAIT_DONE; in WAIT_DONE, ready=1 SHALL assert commit for one cycle and return the FSM to IDLE.
REQ-026 A cycle counter SHALL clear on ISSUE and on every state change; reaching ACK_TIMEOUT in WAIT_BUSY or WAIT_DONE SHALL pulse err_timeout, discard the update (no commit) and return the FSM to IDLE.
REQ-027 Minimum issue-to-issue spacing SHALL be 4 cycles: ISSUE, WAIT_BUSY, WAIT_DONE, IDLE.
REQ-028 change_rq SHALL never assert while ready=0 at the IDLE decision point.
REQ-029 Updates SHALL be issued strictly in push order, and each accepted update SHALL yield exactly one of commit or err_timeout.

Reset
REQ-030 On n_reset=0 the block SHALL immediately set the FSM to IDLE, empty the FIFO, and drive change_rq, commit, err_range, err_timeout, wr_full and fifo_count to 0, and sp_num and ancora_in to 0.
REQ-031 Reset during any handshake state SHALL abandon the in-flight update with no commit or err pulse.
REQ-032 The first push SHALL be accepted on the first edge after n_reset deasserts.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the frame constants (640, 480, MAX_ANCORA) and the field widths (5-bit sprite index, 19-bit anchor).
REQ-034 The FIFO SHALL be a separate sub-module anchor_fifo, 24 bits wide ({sp_num, ancora}), with push, pop, full, empty and count ports.

Verification
REQ-035 Push (3, 1000); responder drops ready 1 cycle after change_rq and raises it 2 cycles later -> change_rq high 1 cycle with sp_num=3, ancora_in=1000; commit pulses once.
REQ-036 Push 8 updates back-to-back with ready held low -> wr_full=1 and fifo_count=8; a 9th push is dropped; releasing ready drains all 8 in order.
REQ-037 Push wr_ancora=307200 -> err_range pulses and fifo_count stays 0; a push of 307199 is accepted.
REQ-038 Push one update; responder keeps ready=1 after change_rq -> err_timeout after 255 cycles in WAIT_BUSY, no commit, FSM in IDLE.
REQ-039 Assert n_reset in WAIT_DONE with 3 entries queued -> all outputs 0 and fifo_count=0; no commit follows deassertion.
REQ-040 Push and pop on the same edge with fifo_count=5 -> fifo_count stays 5.
